round_controller: RTL and testbench

Sequencer for one Memory Matrix round: latches the hidden board, shows it for a fixed number of cycles, then accepts one-hot tile guesses. It checks each guess against the board, accumulates found tiles, counts down remaining misses, and ends the round in WIN or LOSE. It sits between the key/switch front end and the LED/HEX display logic, replacing the free-running guess counter and guess checker with one coordinated FSM.

---
 rtl/round_controller.sv | 153 +++++++++++++++
 tb/tb_round_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Memory Matrix round sequencer: latches the board, shows it for SHOW_CYCLES, then scores one-hot guesses.
// Define MM_REPEAT_PENALTY_EN to make a repeat guess of a found tile cost a miss; by default it is ignored.
module round_controller #(
    parameter int TILES       = 16,
    parameter int SHOW_CYCLES = 100,
    parameter int GUESS_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TILES-1:0]   board_in,
    input  logic [GUESS_W-1:0] guesses_init,
    input  logic               guess_valid,
    input  logic [TILES-1:0]   guess,
    output logic [2:0]         state,
    output logic               show_board,
    output logic [TILES-1:0]   board,
    output logic [TILES-1:0]   found,
    output logic [GUESS_W-1:0] remaining,
    output logic               hit,
    output logic               miss,
    output logic               bad,
    output logic               win,
    output logic               lose
);

    localparam int              CNT_W     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SHOW = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TILES-1:0]   board_q, board_d;
    logic [TILES-1:0]   found_q, found_d;
    logic [GUESS_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               bad_q, bad_d;

    logic start_ok;
    logic take_miss;

    assign start_ok = start && (board_in != '0) && (guesses_init != '0);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        found_d     = found_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        bad_d       = 1'b0;
        take_miss   = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start_ok) begin
                    board_d     = board_in;
                    remaining_d = guesses_init;
                    found_d     = '0;
                    cnt_d       = SHOW_LAST;
                    state_d     = ST_SHOW;
                end
            end

            ST_SHOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_PLAY: begin
                // start is deliberately not looked at here: a guess always wins over a restart.
                if (guess_valid) begin
                    if (!$onehot(guess)) begin
                        bad_d = 1'b1;
                    end else if ((guess & board_q & ~found_q) != '0) begin
                        hit_d   = 1'b1;
                        found_d = found_q | guess;
                        if ((found_q | guess) == board_q) begin
                            state_d = ST_WIN;
                        end
                    end else if ((guess & found_q) != '0) begin
`ifdef MM_REPEAT_PENALTY_EN
                        take_miss = 1'b1;
`else
                        take_miss = 1'b0;
`endif
                    end else begin
                        take_miss = 1'b1;
                    end

                    // LOSE is taken on the step to zero, so remaining never wraps.
                    if (take_miss) begin
                        miss_d      = 1'b1;
                        remaining_d = remaining_q - GUESS_W'(1);
                        if (remaining_q == GUESS_W'(1)) begin
                            state_d = ST_LOSE;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            board_q     <= '0;
            found_q     <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            found_q     <= found_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            bad_q       <= bad_d;
        end
    end

    assign state      = state_q;
    assign show_board = (state_q == ST_SHOW);
    assign win        = (state_q == ST_WIN);
    assign lose       = (state_q == ST_LOSE);
    assign board      = board_q;
    assign found      = found_q;
    assign remaining  = remaining_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign bad        = bad_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with TILES=8, SHOW_CYCLES=4, GUESS_W=4.
module tb_round_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] board_in;
    logic [3:0] guesses_init;
    logic       guess_valid;
    logic [7:0] guess;
    logic [2:0] state;
    logic       show_board;
    logic [7:0] board;
    logic [7:0] found;
    logic [3:0] remaining;
    logic       hit, miss, bad, win, lose;

    int checks = 0;
    int errors = 0;

    round_controller #(.TILES(8), .SHOW_CYCLES(4), .GUESS_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .board_in     (board_in),
        .guesses_init (guesses_init),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .state        (state),
        .show_board   (show_board),
        .board        (board),
        .found        (found),
        .remaining    (remaining),
        .hit          (hit),
        .miss         (miss),
        .bad          (bad),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [3:0] g);
        start = 1'b1; board_in = b; guesses_init = g;
        step();
        start = 1'b0;
    endtask

    task automatic do_guess(input logic [7:0] g);
        guess_valid = 1'b1; guess = g;
        step();
        guess_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; board_in = '0; guesses_init = '0;
        guess_valid = 1'b0; guess = '0;
        step();
        step();
        check("rst_state", state, 0);
        check("rst_board", board, 0);
        check("rst_found", found, 0);
        check("rst_remaining", remaining, 0);
        check("rst_flags", {show_board, hit, miss, bad, win, lose}, 6'b0);

        reset = 1'b1;
        do_start(8'h00, 4'd3);
        check("start_board0_ignored", state, 0);
        do_start(8'h05, 4'd0);
        check("start_budget0_ignored", state, 0);

        // Round 1: board 0x05, budget 3; guesses during SHOW must be ignored.
        do_start(8'h05, 4'd3);
        check("show_state", state, 1);
        check("show_board_0", show_board, 1);
        check("show_latched_board", board, 8'h05);
        for (int i = 0; i < 4; i++) begin
            do_guess(8'h01);
            check($sformatf("show_pulses_%0d", i), {hit, miss, bad}, 3'b000);
            check($sformatf("show_board_%0d", i + 1), show_board, (i < 3) ? 1 : 0);
        end
        check("play_state", state, 2);
        check("play_remaining", remaining, 3);
        check("play_found", found, 0);

        do_guess(8'h03);
        check("bad_pulses", {hit, miss, bad}, 3'b001);
        check("bad_found", found, 0);
        check("bad_remaining", remaining, 3);
        step();
        check("bad_one_cycle", bad, 0);

        do_guess(8'h01);
        check("hit1_pulses", {hit, miss, bad}, 3'b100);
        check("hit1_found", found, 8'h01);
        check("hit1_state", state, 2);

        do_guess(8'h01);
`ifdef MM_REPEAT_PENALTY_EN
        check("repeat_pulses", {hit, miss, bad}, 3'b010);
        check("repeat_remaining", remaining, 2);
`else
        check("repeat_pulses", {hit, miss, bad}, 3'b000);
        check("repeat_remaining", remaining, 3);
`endif
        check("repeat_found", found, 8'h01);

        // Final hit together with a start: start ignored, guess processed.
        start = 1'b1; board_in = 8'h0F; guesses_init = 4'd2;
        do_guess(8'h04);
        start = 1'b0;
        check("hit2_pulses", {hit, miss, bad}, 3'b100);
        check("hit2_found", found, 8'h05);
        check("win_state", state, 3);
        check("win_flag", {win, lose}, 2'b10);
        check("win_board_kept", board, 8'h05);
`ifdef MM_REPEAT_PENALTY_EN
        check("win_remaining", remaining, 2);
`else
        check("win_remaining", remaining, 3);
`endif
        do_guess(8'h02);
        check("win_guess_ignored", {hit, miss, bad}, 3'b000);
        check("win_hold", state, 3);

        // Round 2 from WIN: board 0x05, budget 2, two misses to LOSE.
        do_start(8'h05, 4'd2);
        check("r2_state", state, 1);
        check("r2_found_cleared", found, 0);
        check("r2_remaining", remaining, 2);
        repeat (4) step();
        check("r2_play", state, 2);
        do_guess(8'h02);
        check("miss1_pulses", {hit, miss, bad}, 3'b010);
        check("miss1_remaining", remaining, 1);
        check("miss1_state", state, 2);
        step();
        check("miss_one_cycle", miss, 0);
        do_guess(8'h08);
        check("miss2_pulses", {hit, miss, bad}, 3'b010);
        check("miss2_remaining", remaining, 0);
        check("lose_state", state, 4);
        check("lose_flag", {win, lose}, 2'b01);
        do_guess(8'h01);
        check("lose_guess_ignored", {hit, miss, bad}, 3'b000);
        check("lose_hold", state, 4);
        check("lose_found", found, 0);

        // Round 3 from LOSE, then reset mid-PLAY with a guess pending.
        do_start(8'h05, 4'd3);
        repeat (4) step();
        check("r3_play", state, 2);
        do_guess(8'h01);
        check("r3_found", found, 8'h01);
        reset = 1'b0; guess_valid = 1'b1; guess = 8'h04;
        step();
        reset = 1'b1; guess_valid = 1'b0;
        check("midrst_state", state, 0);
        check("midrst_found", found, 0);
        check("midrst_remaining", remaining, 0);
        check("midrst_pulses", {hit, miss, bad}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
